// File: rtl/restoring_div_n.sv
// Iterative unsigned restoring divider: N-bit quotient and remainder in N+1
// cycles, trial subtraction on a ripple of 4-bit carry-lookahead stages.
module cla_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = c_i;
   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_i);

   assign s_o = p ^ c[3:0];
   assign c_o = c[4];
endmodule

module restoring_div_n #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);
   localparam int CW = $clog2(N + 1);
   localparam int NS = N / 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  r_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  d_q;
   logic          busy_q;
   logic          done_q;
   logic          dbz_q;

   logic [N:0]    t;
   logic [N-1:0]  nd;
   logic [N-1:0]  diff;
   logic [NS:0]   c;
   logic          ok;
   logic [N-1:0]  r_d;
   logic [N-1:0]  q_d;

   assign t    = {r_q, q_q[N-1]};
   assign nd   = ~d_q;
   assign c[0] = 1'b1;

   for (genvar gi = 0; gi < NS; gi++) begin : g_cla
      cla_4 u_cla (
         .a_i (t[4*gi +: 4]),
         .b_i (nd[4*gi +: 4]),
         .c_i (c[gi]),
         .s_o (diff[4*gi +: 4]),
         .c_o (c[gi+1])
      );
   end

   // R stays below D, so R's top bit is always zero and is not stored;
   // the trial's top bit still comes from T[N] with the chain carry.
   assign ok  = t[N] | c[NS];
   assign r_d = ok ? diff : t[N-1:0];
   assign q_d = {q_q[N-2:0], ok};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  cnt_q   <= CW'(N);
                  r_q     <= '0;
                  q_q     <= dividend;
                  d_q     <= divisor;
                  dbz_q   <= (divisor == '0);
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = q_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_div_n.sv
// Directed self-checking bench for restoring_div_n at N=8 and N=16.
module tb_restoring_div_n;
   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [7:0]  dividend = 0;
   logic [7:0]  divisor = 0;
   logic        busy, done, dbz;
   logic [7:0]  quo, rem;

   logic        start16 = 0;
   logic [15:0] dividend16 = 0;
   logic [15:0] divisor16 = 0;
   logic        busy16, done16, dbz16;
   logic [15:0] quo16, rem16;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   restoring_div_n #(.N(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done),
      .quotient(quo), .remainder(rem),
      .div_by_zero(dbz)
   );

   restoring_div_n #(.N(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16),
      .dividend(dividend16), .divisor(divisor16),
      .busy(busy16), .done(done16),
      .quotient(quo16), .remainder(rem16),
      .div_by_zero(dbz16)
   );

   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1;
      dividend = a;
      divisor = b;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         start = 0;
         cyc++;
      end while (!done && cyc < 40);
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      total += 5;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      if (quo !== 8'd0) begin bad++; $display("FAIL rst_quo got=%0d exp=0", quo); end
      if (rem !== 8'd0) begin bad++; $display("FAIL rst_rem got=%0d exp=0", rem); end
      if (dbz !== 1'b0) begin bad++; $display("FAIL rst_dbz got=%b exp=0", dbz); end
      rst = 0;
   endtask

   task automatic test_basic;
      launch(8'd200, 8'd7);
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(negedge clk);
         start = 0;
         total += 2;
         if (busy !== (cyc < 9)) begin
            bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc < 9);
         end
         if (done !== (cyc == 9)) begin
            bad++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, done, cyc == 9);
         end
      end
      total += 3;
      if (quo !== 8'd28) begin bad++; $display("FAIL basic_quo got=%0d exp=28", quo); end
      if (rem !== 8'd4) begin bad++; $display("FAIL basic_rem got=%0d exp=4", rem); end
      if (dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", dbz); end
      @(negedge clk);
      total += 3;
      if (done !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", done); end
      if (quo !== 8'd28) begin bad++; $display("FAIL basic_hold_q got=%0d exp=28", quo); end
      if (rem !== 8'd4) begin bad++; $display("FAIL basic_hold_r got=%0d exp=4", rem); end
   endtask

   task automatic test_boundaries;
      logic [7:0] va [6] = '{8'd255, 8'd5, 8'd255, 8'd0, 8'h9C, 8'd13};
      logic [7:0] vb [6] = '{8'd1, 8'd9, 8'd255, 8'd13, 8'd0, 8'd0};
      logic [7:0] vq [6] = '{8'd255, 8'd0, 8'd1, 8'd0, 8'hFF, 8'hFF};
      logic [7:0] vr [6] = '{8'd0, 8'd5, 8'd0, 8'd0, 8'h9C, 8'd13};
      logic       vz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int cyc;
      for (int i = 0; i < 6; i++) begin
         launch(va[i], vb[i]);
         wait_done(cyc);
         total += 4;
         if (cyc !== 9) begin bad++; $display("FAIL bnd_lat i=%0d got=%0d exp=9", i, cyc); end
         if (quo !== vq[i]) begin bad++; $display("FAIL bnd_quo i=%0d got=%0d exp=%0d", i, quo, vq[i]); end
         if (rem !== vr[i]) begin bad++; $display("FAIL bnd_rem i=%0d got=%0d exp=%0d", i, rem, vr[i]); end
         if (dbz !== vz[i]) begin bad++; $display("FAIL bnd_dbz i=%0d got=%b exp=%b", i, dbz, vz[i]); end
         @(negedge clk);
         total++;
         if (dbz !== vz[i]) begin bad++; $display("FAIL bnd_dbz_hold i=%0d got=%b exp=%b", i, dbz, vz[i]); end
      end
   endtask

   task automatic test_ignored_start;
      int ndone = 0;
      int first = 0;
      logic [7:0] q_at = 0;
      logic [7:0] r_at = 0;
      launch(8'd200, 8'd7);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = (cyc == 3);
         if (cyc == 3) begin
            dividend = 8'd100;
            divisor = 8'd3;
         end
         if (done) begin
            ndone++;
            if (first == 0) begin first = cyc; q_at = quo; r_at = rem; end
         end
      end
      total += 4;
      if (ndone !== 1) begin bad++; $display("FAIL ign_count got=%0d exp=1", ndone); end
      if (first !== 9) begin bad++; $display("FAIL ign_lat got=%0d exp=9", first); end
      if (q_at !== 8'd28) begin bad++; $display("FAIL ign_quo got=%0d exp=28", q_at); end
      if (r_at !== 8'd4) begin bad++; $display("FAIL ign_rem got=%0d exp=4", r_at); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      launch(8'd200, 8'd7);
      wait_done(cyc);
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=9", cyc); end
      if (quo !== 8'd28) begin bad++; $display("FAIL b2b_quo1 got=%0d exp=28", quo); end
      if (rem !== 8'd4) begin bad++; $display("FAIL b2b_rem1 got=%0d exp=4", rem); end
      start = 1;
      dividend = 8'd77;
      divisor = 8'd10;
      wait_done(cyc);
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=9", cyc); end
      if (quo !== 8'd7) begin bad++; $display("FAIL b2b_quo2 got=%0d exp=7", quo); end
      if (rem !== 8'd7) begin bad++; $display("FAIL b2b_rem2 got=%0d exp=7", rem); end
   endtask

   task automatic test_reset_mid;
      int ndone = 0;
      int cyc;
      launch(8'd200, 8'd7);
      repeat (4) begin
         @(negedge clk);
         start = 0;
      end
      rst = 1;
      start = 1;
      @(negedge clk);
      total += 5;
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", done); end
      if (quo !== 8'd0) begin bad++; $display("FAIL mid_quo got=%0d exp=0", quo); end
      if (rem !== 8'd0) begin bad++; $display("FAIL mid_rem got=%0d exp=0", rem); end
      if (dbz !== 1'b0) begin bad++; $display("FAIL mid_dbz got=%b exp=0", dbz); end
      rst = 0;
      start = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      total++;
      if (ndone !== 0) begin bad++; $display("FAIL mid_nodone got=%0d exp=0", ndone); end
      launch(8'd50, 8'd6);
      wait_done(cyc);
      total += 3;
      if (cyc !== 9) begin bad++; $display("FAIL mid_lat got=%0d exp=9", cyc); end
      if (quo !== 8'd8) begin bad++; $display("FAIL mid_quo2 got=%0d exp=8", quo); end
      if (rem !== 8'd2) begin bad++; $display("FAIL mid_rem2 got=%0d exp=2", rem); end
   endtask

   task automatic test_n16;
      logic [15:0] va [3] = '{16'd50000, 16'd65535, 16'd1000};
      logic [15:0] vb [3] = '{16'd123, 16'd256, 16'd0};
      logic [15:0] vq [3] = '{16'd406, 16'd255, 16'hFFFF};
      logic [15:0] vr [3] = '{16'd62, 16'd255, 16'd1000};
      logic        vz [3] = '{1'b0, 1'b0, 1'b1};
      int cyc;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start16 = 1;
         dividend16 = va[i];
         divisor16 = vb[i];
         cyc = 0;
         do begin
            @(negedge clk);
            start16 = 0;
            cyc++;
         end while (!done16 && cyc < 60);
         total += 4;
         if (cyc !== 17) begin bad++; $display("FAIL n16_lat i=%0d got=%0d exp=17", i, cyc); end
         if (quo16 !== vq[i]) begin bad++; $display("FAIL n16_quo i=%0d got=%0d exp=%0d", i, quo16, vq[i]); end
         if (rem16 !== vr[i]) begin bad++; $display("FAIL n16_rem i=%0d got=%0d exp=%0d", i, rem16, vr[i]); end
         if (dbz16 !== vz[i]) begin bad++; $display("FAIL n16_dbz i=%0d got=%b exp=%b", i, dbz16, vz[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_boundaries;
      test_ignored_start;
      test_back_to_back;
      test_reset_mid;
      test_n16;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
